// File: rtl/sdram_sched_pkg.sv
// Shared encodings for the SDRAM burst scheduler: command ops, port IDs,
// FSM states and default widths.
package sdram_sched_pkg;

    localparam int ADDR_W_DEF = 23;
    localparam int LEN_W_DEF  = 9;

    localparam logic [1:0] OP_NONE    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] OP_REFRESH = 2'b11;

    localparam logic [1:0] PORT_WR1 = 2'd0;
    localparam logic [1:0] PORT_RD1 = 2'd1;
    localparam logic [1:0] PORT_RD2 = 2'd2;
    localparam logic [1:0] PORT_REF = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/sdram_port_addr_gen.sv
// Per-port burst address counter: enable flag, deferred LOAD while in flight,
// burst truncation at the wrap limit and wrap-to-base on completion.
module sdram_port_addr_gen #(
    parameter int ADDR_W = 23,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] max_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              load,
    input  logic              in_flight,
    input  logic              done,
    input  logic [LEN_W-1:0]  done_len,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [LEN_W-1:0]  burst_len,
    output logic              enabled
);

    localparam int SUM_W = ADDR_W + 1;

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              en_q, en_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] room;
    logic [SUM_W-1:0]  next_addr;

    always_comb begin
        room      = (max_addr > cnt_q) ? (max_addr - cnt_q) : '0;
        burst_len = (room < ADDR_W'(length)) ? room[LEN_W-1:0] : length;
        next_addr = SUM_W'(cnt_q) + SUM_W'(done_len);

        cnt_d  = cnt_q;
        en_d   = en_q;
        pend_d = pend_q;
        if (done) begin
            // A load that arrived during the burst wins over the increment.
            if (pend_q || load) begin
                cnt_d  = base_addr;
                en_d   = 1'b1;
                pend_d = 1'b0;
            end else if (next_addr >= SUM_W'(max_addr)) begin
                cnt_d = base_addr;
            end else begin
                cnt_d = next_addr[ADDR_W-1:0];
            end
        end else if (load) begin
            if (in_flight) begin
                pend_d = 1'b1;
            end else begin
                cnt_d = base_addr;
                en_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            en_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            pend_q <= pend_d;
        end
    end

    assign cur_addr = cnt_q;
    assign enabled  = en_q;

endmodule

// File: rtl/sdram_port_scheduler.sv
// Burst scheduler for the 4-port SDRAM frame buffer: refresh > WR1 > RD1/RD2
// round-robin, one outstanding burst command at a time.
module sdram_port_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [ADDR_W-1:0] iWR1_ADDR,
    input  logic [ADDR_W-1:0] iWR1_MAX_ADDR,
    input  logic [LEN_W-1:0]  iWR1_LENGTH,
    input  logic              iWR1_LOAD,
    input  logic [LEN_W-1:0]  iWR1_USEDW,
    input  logic [ADDR_W-1:0] iRD1_ADDR,
    input  logic [ADDR_W-1:0] iRD1_MAX_ADDR,
    input  logic [LEN_W-1:0]  iRD1_LENGTH,
    input  logic              iRD1_LOAD,
    input  logic [LEN_W-1:0]  iRD1_USEDW,
    input  logic [ADDR_W-1:0] iRD2_ADDR,
    input  logic [ADDR_W-1:0] iRD2_MAX_ADDR,
    input  logic [LEN_W-1:0]  iRD2_LENGTH,
    input  logic              iRD2_LOAD,
    input  logic [LEN_W-1:0]  iRD2_USEDW,
    input  logic              iREF_REQ,
    output logic              oCMD_VALID,
    input  logic              iCMD_READY,
    output logic [1:0]        oCMD_OP,
    output logic [1:0]        oCMD_PORT,
    output logic [ADDR_W-1:0] oCMD_ADDR,
    output logic [LEN_W-1:0]  oCMD_LEN,
    input  logic              iCMD_DONE,
    output logic              oBUSY
);

    logic [2:0][ADDR_W-1:0] base_a, max_a, cur_a;
    logic [2:0][LEN_W-1:0]  length_a, blen_a;
    logic [2:0]             load_a, en_a, flight_a, done_a;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              rr_q, rr_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic       req_wr1, req_rd1, req_rd2, req_any;
    logic [1:0] grant;

    assign base_a   = {iRD2_ADDR, iRD1_ADDR, iWR1_ADDR};
    assign max_a    = {iRD2_MAX_ADDR, iRD1_MAX_ADDR, iWR1_MAX_ADDR};
    assign length_a = {iRD2_LENGTH, iRD1_LENGTH, iWR1_LENGTH};
    assign load_a   = {iRD2_LOAD, iRD1_LOAD, iWR1_LOAD};

    for (genvar p = 0; p < 3; p++) begin : g_port
        // In flight from the ARB cycle that grants it until DONE.
        assign flight_a[p] = (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (port_q == 2'(p)))
                          || ((state_q == ST_ARB) && req_any && (grant == 2'(p)));
        assign done_a[p]   = iCMD_DONE && (state_q == ST_WAIT) && (port_q == 2'(p));

        sdram_port_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
            .clk       (iCLK),
            .rst       (iRST),
            .base_addr (base_a[p]),
            .max_addr  (max_a[p]),
            .length    (length_a[p]),
            .load      (load_a[p]),
            .in_flight (flight_a[p]),
            .done      (done_a[p]),
            .done_len  (len_q),
            .cur_addr  (cur_a[p]),
            .burst_len (blen_a[p]),
            .enabled   (en_a[p])
        );
    end

    always_comb begin
        req_wr1 = en_a[0] && (iWR1_USEDW >= iWR1_LENGTH) && (iWR1_LENGTH != '0);
        req_rd1 = en_a[1] && (iRD1_USEDW < iRD1_LENGTH) && (iRD1_LENGTH != '0);
        req_rd2 = en_a[2] && (iRD2_USEDW < iRD2_LENGTH) && (iRD2_LENGTH != '0);

        req_any = 1'b1;
        grant   = PORT_WR1;
        if (iREF_REQ)                grant = PORT_REF;
        else if (req_wr1)            grant = PORT_WR1;
        else if (req_rd1 && req_rd2) grant = rr_q ? PORT_RD2 : PORT_RD1;
        else if (req_rd1)            grant = PORT_RD1;
        else if (req_rd2)            grant = PORT_RD2;
        else                         req_any = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        rr_d    = rr_q;
        op_d    = op_q;
        port_d  = port_q;
        addr_d  = addr_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: state_d = ST_ARB;
            ST_ARB: begin
                if (req_any) begin
                    state_d = ST_ISSUE;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    port_d  = grant;
                    case (grant)
                        PORT_WR1: begin op_d = OP_WRITE; addr_d = cur_a[0]; len_d = blen_a[0]; end
                        PORT_RD1: begin op_d = OP_READ;  addr_d = cur_a[1]; len_d = blen_a[1]; end
                        PORT_RD2: begin op_d = OP_READ;  addr_d = cur_a[2]; len_d = blen_a[2]; end
                        default:  begin op_d = OP_REFRESH; addr_d = '0; len_d = '0; end
                    endcase
                    if ((grant == PORT_RD1) || (grant == PORT_RD2)) rr_d = (grant == PORT_RD1);
                end
            end
            ST_ISSUE: begin
                if (iCMD_READY) begin
                    valid_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (iCMD_DONE) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            rr_q    <= 1'b0;
            op_q    <= OP_NONE;
            port_q  <= 2'd0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            rr_q    <= rr_d;
            op_q    <= op_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    assign oCMD_VALID = valid_q;
    assign oCMD_OP    = op_q;
    assign oCMD_PORT  = port_q;
    assign oCMD_ADDR  = addr_q;
    assign oCMD_LEN   = len_q;
    assign oBUSY      = busy_q;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Bench for sdram_port_scheduler: table of arbitration vectors plus hand
// sequences for wrap/truncation, deferred LOAD, READY stall and reset in WAIT.
module tb_sdram_port_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [22:0] wr1_addr, wr1_max, rd1_addr, rd1_max, rd2_addr, rd2_max;
    logic [8:0]  wr1_len, wr1_usedw, rd1_len, rd1_usedw, rd2_len, rd2_usedw;
    logic        wr1_load, rd1_load, rd2_load, ref_req, cmd_ready, cmd_done;
    logic        cmd_valid, busy;
    logic [1:0]  cmd_op, cmd_port;
    logic [22:0] cmd_addr;
    logic [8:0]  cmd_len;

    sdram_port_scheduler #(.ADDR_W(23), .LEN_W(9)) dut (
        .iCLK(clk), .iRST(rst),
        .iWR1_ADDR(wr1_addr), .iWR1_MAX_ADDR(wr1_max), .iWR1_LENGTH(wr1_len),
        .iWR1_LOAD(wr1_load), .iWR1_USEDW(wr1_usedw),
        .iRD1_ADDR(rd1_addr), .iRD1_MAX_ADDR(rd1_max), .iRD1_LENGTH(rd1_len),
        .iRD1_LOAD(rd1_load), .iRD1_USEDW(rd1_usedw),
        .iRD2_ADDR(rd2_addr), .iRD2_MAX_ADDR(rd2_max), .iRD2_LENGTH(rd2_len),
        .iRD2_LOAD(rd2_load), .iRD2_USEDW(rd2_usedw),
        .iREF_REQ(ref_req),
        .oCMD_VALID(cmd_valid), .iCMD_READY(cmd_ready),
        .oCMD_OP(cmd_op), .oCMD_PORT(cmd_port), .oCMD_ADDR(cmd_addr), .oCMD_LEN(cmd_len),
        .iCMD_DONE(cmd_done), .oBUSY(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  port;
        logic [22:0] addr;
        logic [8:0]  len;
    } cmd_t;

    typedef struct {
        logic        refr;
        logic [8:0]  wr_u;
        logic [8:0]  rd1_u;
        logic [8:0]  rd2_u;
        cmd_t        exp;
    } vec_t;

    cmd_t exp_q[$];
    vec_t vecs[14];
    int   n_pass = 0;
    int   n_total = 0;
    int   t_done = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    endtask

    task automatic push_exp(input logic [1:0] op, input logic [1:0] port,
                            input logic [22:0] addr, input logic [8:0] len);
        cmd_t c;
        c.op = op; c.port = port; c.addr = addr; c.len = len;
        exp_q.push_back(c);
    endtask

    // Waits for a command, checks it against the scoreboard head, optionally
    // stalls READY for `hold` cycles (with a stray DONE mid-stall), then accepts.
    task automatic get_cmd(input int hold, input bit chk_lat);
        cmd_t e;
        int   n = 0;
        while (!cmd_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        if (!cmd_valid) begin
            n_total++;
            $display("FAIL cmd_timeout: no oCMD_VALID, required port %0d addr %0d", e.port, e.addr);
            return;
        end
        if (chk_lat) check("done_to_valid", cyc - t_done, 3);
        check("cmd_op", cmd_op, e.op);
        check("cmd_port", cmd_port, e.port);
        check("cmd_addr", cmd_addr, e.addr);
        check("cmd_len", cmd_len, e.len);
        for (int k = 0; k < hold; k++) begin
            cmd_done = (k == 4);
            @(negedge clk);
            check("stall_valid", cmd_valid, 1);
            check("stall_fields", {cmd_op, cmd_port, cmd_addr, cmd_len}, e);
        end
        cmd_done  = 1'b0;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("valid_after_accept", cmd_valid, 0);
        check("busy_in_wait", busy, 1);
    endtask

    task automatic finish_burst();
        cmd_done = 1'b1;
        t_done   = cyc;
        @(negedge clk);
        cmd_done = 1'b0;
    endtask

    task automatic set_levels(input logic r, input logic [8:0] w, input logic [8:0] r1, input logic [8:0] r2);
        ref_req = r; wr1_usedw = w; rd1_usedw = r1; rd2_usedw = r2;
    endtask

    initial begin
        bit saw;
        // WR1 0..640 len 128; RD1 1000..2000 len 100; RD2 5000..5300 len 200.
        vecs[0]  = '{1'b0, 9'd128, 9'd100, 9'd200, '{2'd1, 2'd0, 23'd0,    9'd128}};
        vecs[1]  = '{1'b0, 9'd128, 9'd100, 9'd200, '{2'd1, 2'd0, 23'd128,  9'd128}};
        vecs[2]  = '{1'b0, 9'd200, 9'd100, 9'd200, '{2'd1, 2'd0, 23'd256,  9'd128}};
        vecs[3]  = '{1'b0, 9'd128, 9'd100, 9'd200, '{2'd1, 2'd0, 23'd384,  9'd128}};
        vecs[4]  = '{1'b0, 9'd128, 9'd100, 9'd200, '{2'd1, 2'd0, 23'd512,  9'd128}};
        vecs[5]  = '{1'b0, 9'd128, 9'd100, 9'd200, '{2'd1, 2'd0, 23'd0,    9'd128}};
        vecs[6]  = '{1'b0, 9'd127, 9'd99,  9'd0,   '{2'd2, 2'd1, 23'd1000, 9'd100}};
        vecs[7]  = '{1'b0, 9'd0,   9'd0,   9'd0,   '{2'd2, 2'd2, 23'd5000, 9'd200}};
        vecs[8]  = '{1'b0, 9'd0,   9'd0,   9'd0,   '{2'd2, 2'd1, 23'd1100, 9'd100}};
        vecs[9]  = '{1'b1, 9'd128, 9'd0,   9'd200, '{2'd3, 2'd3, 23'd0,    9'd0}};
        vecs[10] = '{1'b0, 9'd128, 9'd0,   9'd200, '{2'd1, 2'd0, 23'd128,  9'd128}};
        vecs[11] = '{1'b0, 9'd0,   9'd0,   9'd200, '{2'd2, 2'd1, 23'd1200, 9'd100}};
        vecs[12] = '{1'b0, 9'd0,   9'd0,   9'd0,   '{2'd2, 2'd2, 23'd5200, 9'd100}};
        vecs[13] = '{1'b0, 9'd0,   9'd100, 9'd0,   '{2'd2, 2'd2, 23'd5000, 9'd200}};

        rst = 1'b1;
        wr1_addr = 23'd0;    wr1_max = 23'd640;  wr1_len = 9'd128;
        rd1_addr = 23'd1000; rd1_max = 23'd2000; rd1_len = 9'd100;
        rd2_addr = 23'd5000; rd2_max = 23'd5300; rd2_len = 9'd200;
        wr1_load = 0; rd1_load = 0; rd2_load = 0;
        cmd_ready = 0; cmd_done = 0;
        set_levels(1'b0, 9'd128, 9'd0, 9'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", cmd_valid, 0);
        check("rst_fields", {cmd_op, cmd_port, cmd_addr, cmd_len}, 0);
        check("rst_busy", busy, 0);

        // Requests are present but no port has been loaded yet.
        saw = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_valid) saw = 1;
        end
        check("no_req_before_load", saw, 0);

        set_levels(1'b0, 9'd0, 9'd100, 9'd200);
        wr1_load = 1; rd1_load = 1; rd2_load = 1;
        @(negedge clk);
        wr1_load = 0; rd1_load = 0; rd2_load = 0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            set_levels(vecs[i].refr, vecs[i].wr_u, vecs[i].rd1_u, vecs[i].rd2_u);
            exp_q.push_back(vecs[i].exp);
            get_cmd(0, i > 0);
            finish_burst();
        end

        // Max 600: fifth burst truncated to 88 words, then wrap to base.
        set_levels(1'b0, 9'd0, 9'd100, 9'd200);
        wr1_max  = 23'd600;
        wr1_load = 1;
        @(negedge clk);
        wr1_load = 0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            set_levels(1'b0, 9'd128, 9'd100, 9'd200);
            push_exp(2'd1, 2'd0, (i < 5) ? 23'(i * 128) : 23'((i - 5) * 128), (i == 4) ? 9'd88 : 9'd128);
            get_cmd(0, i > 0);
            finish_burst();
        end

        // LOAD while the burst at 256 is outstanding: next burst restarts at base.
        push_exp(2'd1, 2'd0, 23'd256, 9'd128);
        get_cmd(0, 1);
        wr1_load = 1;
        @(negedge clk);
        wr1_load = 0;
        @(negedge clk);
        finish_burst();
        push_exp(2'd1, 2'd0, 23'd0, 9'd128);
        get_cmd(0, 0);
        finish_burst();

        // READY held low 10 cycles with a stray DONE during ISSUE.
        push_exp(2'd1, 2'd0, 23'd128, 9'd128);
        get_cmd(10, 1);
        finish_burst();

        // Reset while WAITing.
        push_exp(2'd1, 2'd0, 23'd256, 9'd128);
        get_cmd(0, 1);
        rst = 1'b1;
        #1;
        check("midrst_valid", cmd_valid, 0);
        check("midrst_fields", {cmd_op, cmd_port, cmd_addr, cmd_len}, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        set_levels(1'b0, 9'd128, 9'd0, 9'd0);
        saw = 0;
        repeat (30) begin
            @(negedge clk);
            if (cmd_valid) saw = 1;
        end
        check("ports_disabled_after_rst", saw, 0);

        wr1_load = 1;
        @(negedge clk);
        wr1_load = 0;
        push_exp(2'd1, 2'd0, 23'd0, 9'd128);
        get_cmd(0, 0);
        finish_burst();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
